// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the request cycle; misses stall while a victim is written back and the line refilled.
module dcache_ctrl #(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_BYTES = 32,
  localparam int unsigned LINE_W    = 8 * LINE_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned OFFSET_W = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int unsigned WORD_W   = OFFSET_W - 2;

  typedef enum logic [1:0] {StIdle, StWb, StFetch, StUpdate} state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [LINE_W-1:0]    fill_q;
  logic [TAG_W-1:0]     miss_tag_q;
  logic [INDEX_W-1:0]   miss_idx_q;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [WORD_W-1:0]  word;
  logic [WORD_W+4:0]  word_bit;
  logic               hit, store_hit;
  logic               unused_addr;

  assign tag         = addr_i[31 -: TAG_W];
  assign idx         = addr_i[OFFSET_W +: INDEX_W];
  assign word        = addr_i[2 +: WORD_W];
  assign word_bit    = {word, 5'b0};
  assign unused_addr = ^addr_i[1:0];

  assign hit       = req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign store_hit = hit & we_i & (state_q == StIdle);
  assign stall_o   = req_i & ((state_q != StIdle) | ~hit);
  assign rdata_o   = (hit & ~we_i) ? data_q[idx][word_bit +: 32] : 32'h0;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // Memory outputs are loaded on entry to each phase so they stay stable while mem_req_o is high.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_i && !hit) begin
          mem_req_d = 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = StWb;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx], idx, {OFFSET_W{1'b0}}};
            mem_wdata_d = data_q[idx];
          end else begin
            state_d    = StFetch;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, {OFFSET_W{1'b0}}};
          end
        end
      end
      StWb: begin
        if (mem_ack_i) begin
          state_d    = StFetch;
          mem_we_d   = 1'b0;
          mem_addr_d = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
        end
      end
      StFetch: begin
        if (mem_ack_i) begin
          state_d   = StUpdate;
          mem_req_d = 1'b0;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (store_hit) dirty_q[idx] <= 1'b1;
      if (state_q == StUpdate) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  // Tag/data storage is not reset; updates are suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (state_q == StIdle && req_i && !hit) begin
        miss_tag_q <= tag;
        miss_idx_q <= idx;
      end
      if (state_q == StFetch && mem_ack_i) fill_q <= mem_rdata_i;
      if (store_hit) data_q[idx][word_bit +: 32] <= wdata_i;
      if (state_q == StUpdate) begin
        data_q[miss_idx_q] <= fill_q;
        tag_q[miss_idx_q]  <= miss_tag_q;
      end
    end
  end

endmodule
